mmio_led_pwm: RTL and testbench
===============================

MMIO_LED_PWM -- requirements
Module: mmio_led_pwm

Interface
REQ-001 SHALL have parameter ADDR, default 32'hFFFFFFFC, word address of the LED control register.
REQ-002 SHALL have parameter PRESCALE, default 1, number of clk cycles per PWM count step; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  single clock for all state; all registers update on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port dmem_wren  input  1  write strobe from the bus initiator, sampled each rising edge.
REQ-006 SHALL have port funct3  input  3  access size: 000 byte, 001 halfword, 010 word.
REQ-007 SHALL have port dmem_address  input  32  byte address of the access.
REQ-008 SHALL have port dmem_data_in  input  32  write data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-009 SHALL have port dmem_data_out  output  32  registered readback of the control register.
REQ-010 SHALL have ports led, red, green, blue  output  1 each  active-high PWM outputs.

Function
REQ-011 SHALL hold a 32-bit control register CTRL: [31:24] led duty, [23:16] red duty, [15:8] green duty, [7:0] blue duty.
REQ-012 SHALL decode a hit when dmem_address[31:2] == ADDR[31:2]; a non-hit write SHALL leave CTRL unchanged.
REQ-013 SHALL on a hit with dmem_wren=1 write lanes by funct3 and dmem_address[1:0]: byte to lane [1:0]; halfword to lanes 0-1 (offset 0) or 2-3 (offset 2); word to all lanes (offset 0).
REQ-014 SHALL ignore misaligned writes (halfword at offset 1 or 3, word at offset 1, 2 or 3) and any funct3 other than 000/001/010.
REQ-015 SHALL update dmem_data_out one cycle after any hit to the current CTRL (read-before-write on a same-cycle write), and hold its previous value on non-hit cycles.
REQ-016 SHALL run a prescaler 0..PRESCALE-1, asserting tick for one cycle when it equals PRESCALE-1, then wrapping to 0.
REQ-017 SHALL advance an 8-bit pwm_cnt on each tick, wrapping 255 -> 0; a tick with pwm_cnt == 255 SHALL be a period boundary.
REQ-018 SHALL hold four 8-bit active duties, loaded only at period boundaries so a CTRL write never glitches a period in progress.
REQ-019 SHALL, when a write and a period boundary coincide, load the active duties from the pre-write CTRL; the new value takes effect at the following boundary.
REQ-020 SHALL register each output as (pwm_cnt < active duty) with one cycle latency: duty 0 always low, duty 255 high 255 of every 256 counts.

Reset
REQ-021 SHALL on reset_n low immediately clear CTRL, active duties, prescaler, pwm_cnt, dmem_data_out and all four PWM outputs to 0.
REQ-022 SHALL resume from all-zero state on the first rising edge after reset_n deasserts; a reset asserted mid-period SHALL abort the period with no partial update retained.

Configuration
REQ-023 SHALL, with macro LED_PWM_FADE_EN defined, at each period boundary step every active duty by +1 toward, or -1 toward, its CTRL lane, holding when equal.
REQ-024 SHALL, with LED_PWM_FADE_EN undefined, load every active duty directly from CTRL at each period boundary.

Verification (PRESCALE=1)
REQ-025 SHALL cover reset: reset_n=0 mid-period with CTRL=32'hFFFFFFFF -> all outputs and dmem_data_out 0 within the same cycle.
REQ-026 SHALL cover word write: SW 32'hFFFF0000 at 32'hFFFFFFFC -> dmem_data_out=32'hFFFF0000 next cycle; after the next boundary led and red high 255/256 cycles, green and blue 0.
REQ-027 SHALL cover byte write: SB data 32'h00000080 at 32'hFFFFFFFD -> CTRL=32'h00008000; green high exactly 128 of 256 cycles per period.
REQ-028 SHALL cover rejects: SH at 32'hFFFFFFFF, SW at 32'hFFFFFFFE, SW at 32'h00000100, funct3=011 -> CTRL unchanged.
REQ-029 SHALL cover boundary collision: SW 32'h000000FF landing on a period-boundary cycle -> blue stays 0 for that period and switches at the next boundary.
REQ-030 SHALL cover fade: blue 0 -> write 8'h04; with LED_PWM_FADE_EN active blue duty reaches 4 after 4 boundaries; without it, after 1.

Source files
------------

// File: rtl/mmio_led_pwm.sv
// Memory-mapped four-channel LED PWM: one 32-bit duty register, period-synchronous duty reload.
// Optional macro LED_PWM_FADE_EN: active duties ramp by one count per period instead of jumping.
module mmio_led_pwm #(
    parameter logic [31:0] ADDR     = 32'hFFFFFFFC,
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        dmem_wren,
    input  logic [2:0]  funct3,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    output logic [31:0] dmem_data_out,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    // Lane 3 = led, lane 2 = red, lane 1 = green, lane 0 = blue.
    logic [31:0]      ctrl_q, ctrl_d;
    logic [31:0]      dout_q, dout_d;
    logic [15:0]      presc_q, presc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [3:0][7:0]  duty_q, duty_d;
    logic [3:0]       out_q, out_d;

    logic             hit_s;
    logic             wr_en_s;
    logic             tick_s;
    logic             boundary_s;
    logic [3:0]       wr_mask_s;
    logic [31:0]      wr_data_s;

    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        logic [7:0] res;
        if (cur < tgt) begin
            res = cur + 8'd1;
        end else if (cur > tgt) begin
            res = cur - 8'd1;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    assign hit_s      = (dmem_address[31:2] == ADDR[31:2]);
    assign wr_en_s    = hit_s && dmem_wren;
    assign tick_s     = (presc_q == PRESC_MAX);
    assign boundary_s = tick_s && (cnt_q == 8'hFF);

    // Lane enables and lane-replicated data; misaligned or unknown sizes enable nothing.
    always_comb begin
        wr_mask_s = 4'b0000;
        wr_data_s = 32'h0000_0000;
        case (funct3)
            3'b000: begin
                wr_mask_s = 4'b0001 << dmem_address[1:0];
                wr_data_s = {4{dmem_data_in[7:0]}};
            end
            3'b001: begin
                wr_data_s = {2{dmem_data_in[15:0]}};
                if (dmem_address[0] == 1'b0) begin
                    wr_mask_s = dmem_address[1] ? 4'b1100 : 4'b0011;
                end else begin
                    wr_mask_s = 4'b0000;
                end
            end
            3'b010: begin
                wr_data_s = dmem_data_in;
                if (dmem_address[1:0] == 2'b00) begin
                    wr_mask_s = 4'b1111;
                end else begin
                    wr_mask_s = 4'b0000;
                end
            end
            default: begin
                wr_mask_s = 4'b0000;
                wr_data_s = 32'h0000_0000;
            end
        endcase
    end

    // Next-state for register file, readback, timebase, duties and outputs.
    always_comb begin
        ctrl_d  = ctrl_q;
        duty_d  = duty_q;
        out_d   = 4'b0000;
        dout_d  = hit_s ? ctrl_q : dout_q;
        presc_d = tick_s ? 16'd0 : presc_q + 16'd1;
        cnt_d   = tick_s ? cnt_q + 8'd1 : cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (wr_en_s && wr_mask_s[i]) begin
                ctrl_d[8*i +: 8] = wr_data_s[8*i +: 8];
            end else begin
                ctrl_d[8*i +: 8] = ctrl_q[8*i +: 8];
            end
            // Duties sample the pre-write register so a colliding write waits a period.
            if (boundary_s) begin
`ifdef LED_PWM_FADE_EN
                duty_d[i] = step_toward(duty_q[i], ctrl_q[8*i +: 8]);
`else
                duty_d[i] = ctrl_q[8*i +: 8];
`endif
            end else begin
                duty_d[i] = duty_q[i];
            end
            out_d[i] = (cnt_q < duty_q[i]);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q  <= 32'h0000_0000;
            dout_q  <= 32'h0000_0000;
            presc_q <= 16'd0;
            cnt_q   <= 8'd0;
            duty_q  <= '0;
            out_q   <= 4'b0000;
        end else begin
            ctrl_q  <= ctrl_d;
            dout_q  <= dout_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            out_q   <= out_d;
        end
    end

    assign dmem_data_out = dout_q;
    assign led           = out_q[3];
    assign red           = out_q[2];
    assign green         = out_q[1];
    assign blue          = out_q[0];

endmodule

// File: tb/tb_mmio_led_pwm.sv
// Self-checking bench for mmio_led_pwm: table vectors, period-count sequences and random traffic vs a cycle model.
module tb_mmio_led_pwm;

    localparam logic [31:0] A = 32'hFFFFFFFC;
    localparam int          P = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dmem_wren = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] dmem_address = 32'h0;
    logic [31:0] dmem_data_in = 32'h0;
    logic [31:0] dmem_data_out;
    logic        led, red, green, blue;

    int checks = 0;
    int errors = 0;

    // Reference state: t counts rising edges since reset release.
    int          t = 0;
    logic [31:0] m_ctrl = 32'h0;
    logic [31:0] m_dout = 32'h0;
    logic [7:0]  m_duty [4];
    logic [3:0]  m_out = 4'b0;
    int          pc [4];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_ctrl;
    } vec_t;
    vec_t vecs [13];

    mmio_led_pwm #(.ADDR(A), .PRESCALE(P)) dut (
        .clk(clk), .reset_n(reset_n), .dmem_wren(dmem_wren), .funct3(funct3),
        .dmem_address(dmem_address), .dmem_data_in(dmem_data_in),
        .dmem_data_out(dmem_data_out), .led(led), .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("FAIL %s actual %h required %h (t=%0d)", name, act, exp, t);
        end
    endtask

    function automatic logic [31:0] apply_write(input logic [31:0] c, input logic [2:0] f,
                                                input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        int off;
        r = c;
        off = int'(a[1:0]);
        case (f)
            3'b000: r[8*off +: 8] = d[7:0];
            3'b001: begin
                if (off == 0) r[15:0] = d[15:0];
                else if (off == 2) r[31:16] = d[15:0];
            end
            3'b010: if (off == 0) r = d;
            default: r = c;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] next_duty(input logic [7:0] cur, input logic [7:0] tgt);
`ifdef LED_PWM_FADE_EN
        if (cur < tgt) return cur + 8'd1;
        if (cur > tgt) return cur - 8'd1;
        return cur;
`else
        return tgt;
`endif
    endfunction

    task automatic model_reset();
        t = 0;
        m_ctrl = 32'h0;
        m_dout = 32'h0;
        m_out = 4'b0;
        for (int i = 0; i < 4; i++) m_duty[i] = 8'h00;
    endtask

    // One clock: drive, advance the model from pre-edge state, compare everything after the edge.
    task automatic cycle(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        int cnt;
        bit tick, bnd, hit;
        dmem_wren = w;
        funct3 = f;
        dmem_address = a;
        dmem_data_in = d;
        @(posedge clk);
        cnt  = (t / P) % 256;
        tick = ((t % P) == P - 1);
        bnd  = tick && (cnt == 255);
        hit  = (a[31:2] == A[31:2]);
        for (int i = 0; i < 4; i++) m_out[i] = (cnt < int'(m_duty[i]));
        if (hit) m_dout = m_ctrl;
        if (bnd) for (int i = 0; i < 4; i++) m_duty[i] = next_duty(m_duty[i], m_ctrl[8*i +: 8]);
        if (hit && w) m_ctrl = apply_write(m_ctrl, f, a, d);
        t++;
        #1;
        chk("cycle", {28'h0, dmem_data_out, led, red, green, blue}, {28'h0, m_dout, m_out});
    endtask

    task automatic idle();
        cycle(1'b0, 3'b010, 32'h0000_0000, 32'h0);
    endtask

    task automatic rd();
        cycle(1'b0, 3'b010, A, 32'h0);
    endtask

    task automatic wr(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        cycle(1'b1, f, a, d);
    endtask

    // Idle until the next pre-edge count equals phase.
    task automatic run_until(input int phase);
        while ((t % (256 * P)) != phase * P) idle();
    endtask

    task automatic count_period();
        for (int i = 0; i < 4; i++) pc[i] = 0;
        for (int k = 0; k < 256 * P; k++) begin
            idle();
            pc[3] += int'(led);
            pc[2] += int'(red);
            pc[1] += int'(green);
            pc[0] += int'(blue);
        end
    endtask

    initial begin
        int fade_exp [4];
        logic [31:0] ra;
`ifdef LED_PWM_FADE_EN
        fade_exp = '{1, 2, 3, 4};
`else
        fade_exp = '{4, 4, 4, 4};
`endif
        vecs[0]  = '{3'b010, 32'hFFFFFFFC, 32'h00000000, 32'h00000000};
        vecs[1]  = '{3'b000, 32'hFFFFFFFD, 32'h00000080, 32'h00008000};
        vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'h00001234, 32'h00008000};
        vecs[3]  = '{3'b010, 32'hFFFFFFFE, 32'h00000055, 32'h00008000};
        vecs[4]  = '{3'b010, 32'h00000100, 32'h0000AAAA, 32'h00008000};
        vecs[5]  = '{3'b011, 32'hFFFFFFFC, 32'h12345678, 32'h00008000};
        vecs[6]  = '{3'b001, 32'hFFFFFFFE, 32'h0000BEEF, 32'hBEEF8000};
        vecs[7]  = '{3'b001, 32'hFFFFFFFC, 32'h00001234, 32'hBEEF1234};
        vecs[8]  = '{3'b000, 32'hFFFFFFFF, 32'h000000A5, 32'hA5EF1234};
        vecs[9]  = '{3'b000, 32'hFFFFFFFC, 32'h0000003C, 32'hA5EF123C};
        vecs[10] = '{3'b010, 32'hFFFFFFFC, 32'hFFFF0000, 32'hFFFF0000};
        vecs[11] = '{3'b001, 32'hFFFFFFFD, 32'h00001111, 32'hFFFF0000};
        vecs[12] = '{3'b100, 32'hFFFFFFFC, 32'h00000000, 32'hFFFF0000};

        model_reset();
        #1;
        chk("reset_state", {28'h0, dmem_data_out, led, red, green, blue}, 64'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Fade: blue 0 -> 4, observed per period.
        wr(3'b000, A, 32'h00000004);
        run_until(0);
        for (int p = 0; p < 4; p++) begin
            count_period();
            chk("fade_blue_period", 64'(pc[0]), 64'(fade_exp[p]));
        end

        foreach (vecs[i]) begin
            wr(vecs[i].f3, vecs[i].addr, vecs[i].data);
            rd();
            chk("table_ctrl", {32'h0, dmem_data_out}, {32'h0, vecs[i].exp_ctrl});
        end

`ifndef LED_PWM_FADE_EN
        run_until(0);
        idle();
        run_until(0);
        count_period();
        chk("word_led", 64'(pc[3]), 64'd255);
        chk("word_red", 64'(pc[2]), 64'd255);
        chk("word_gb", 64'(pc[1] + pc[0]), 64'd0);

        wr(3'b010, A, 32'h0);
        wr(3'b000, 32'hFFFFFFFD, 32'h00000080);
        rd();
        chk("byte_ctrl", {32'h0, dmem_data_out}, 64'h0000_8000);
        run_until(0);
        idle();
        run_until(0);
        count_period();
        chk("byte_green", 64'(pc[1]), 64'd128);
        chk("byte_others", 64'(pc[3] + pc[2] + pc[0]), 64'd0);

        wr(3'b010, A, 32'h0);
        run_until(0);
        idle();
        run_until(255);
        wr(3'b010, A, 32'h000000FF);
        count_period();
        chk("collision_blue_hold", 64'(pc[0]), 64'd0);
        count_period();
        chk("collision_blue_next", 64'(pc[0]), 64'd255);
`endif

        for (int k = 0; k < 3000; k++) begin
            ra = ($urandom_range(0, 9) < 7) ? {A[31:2], 2'($urandom_range(0, 3))} : 32'($urandom);
            cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), ra, 32'($urandom));
        end

        // Asynchronous reset mid-period with everything lit.
        wr(3'b010, A, 32'hFFFFFFFF);
        run_until(0);
        idle();
        run_until(100);
        rd();
        reset_n = 1'b0;
        #1;
        chk("reset_async", {28'h0, dmem_data_out, led, red, green, blue}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < 300; k++) idle();
        rd();
        chk("reset_ctrl_cleared", {32'h0, dmem_data_out}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
